// File: rtl/jsq4_1_ctr_pkg.sv
// ----------------------------------------------------------------------------
// jsq4_1_ctr_pkg
// Project constants and shared types for the triggered pulse generator.
//   JSQ_DEFAULT_PULSE_LEN : default enable-window length in clock cycles,
//                           shared with any block that must agree on it.
//   jsq_state_e           : IDLE / RUN state encoding of the pulse FSM.
// ----------------------------------------------------------------------------
package jsq4_1_ctr_pkg;

    localparam int unsigned JSQ_DEFAULT_PULSE_LEN = 10;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } jsq_state_e;

endpackage : jsq4_1_ctr_pkg

// File: rtl/jsq4_1_ctr.sv
// ----------------------------------------------------------------------------
// jsq4_1_ctr
// Triggered pulse generator. A start strobe on en, sampled while idle, makes
// dout go high for exactly PULSE_LEN clock cycles, then the block idles again.
// Strobes seen during a run are ignored (no retrigger, no extension).
//
// Ports:
//   clk   : system clock, rising-edge active
//   rst_n : asynchronous reset, active HIGH despite the name; clears the
//           counter, the run flag and dout immediately
//   en    : start strobe, synchronous to clk, level-sampled only in IDLE
//   dout  : registered pulse output, equal to the run flag at all times
// ----------------------------------------------------------------------------
module jsq4_1_ctr
    import jsq4_1_ctr_pkg::*;
#(
    parameter int unsigned PULSE_LEN = JSQ_DEFAULT_PULSE_LEN
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic dout
);

    // Counter width is derived from the pulse length and must not be overridden.
    localparam int unsigned CNT_W = $clog2(PULSE_LEN + 1);

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PULSE_LEN);

    jsq_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic             dout_q,  dout_d;

    // Next-state logic. The counter holds the number of high cycles already
    // delivered in the current run: it is loaded with 1 on the start edge, so
    // reaching PULSE_LEN means the last high cycle is in progress and the next
    // edge ends the run. The counter therefore never exceeds PULSE_LEN.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        dout_d  = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (en) begin
                    state_d = ST_RUN;
                    cnt_d   = CNT_ONE;
                end
            end
            ST_RUN: begin
                if (cnt_q == CNT_LAST) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d   = cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase

        // dout is registered from the next run flag so it tracks busy exactly.
        dout_d = (state_d == ST_RUN);
    end

    // State, counter and output registers with asynchronous active-high clear.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            dout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dout_q  <= dout_d;
        end
    end

    assign dout = dout_q;

endmodule : jsq4_1_ctr

// File: tb/tb_jsq4_1_ctr.sv
// ----------------------------------------------------------------------------
// tb_jsq4_1_ctr
// Directed testbench for jsq4_1_ctr with the default PULSE_LEN of 10.
// Inputs change and outputs are sampled on the falling clock edge.
// ----------------------------------------------------------------------------
module tb_jsq4_1_ctr;

    localparam int PLEN = 10;

    logic clk;
    logic rst_n;
    logic en;
    logic dout;

    int vectorCount;
    int missCount;
    int riseCount;
    logic prevDout;

    jsq4_1_ctr #(.PULSE_LEN(PLEN)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (en),
        .dout  (dout)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Drive both inputs, then advance to the next falling edge.
    task automatic applyStimulus(input logic enVal, input logic rstVal);
        en    = enVal;
        rst_n = rstVal;
        @(negedge clk);
    endtask

    // Compare dout against the hand-computed value.
    task automatic checkOutput(input string tag, input logic expVal);
        vectorCount++;
        assert (dout === expVal) else begin
            missCount++;
            $error("[TB] FAIL %s: dout=%b expected %b", tag, dout, expVal);
        end
    endtask

    // Compare the internal run counter against a hand-computed value.
    task automatic checkCount(input string tag, input int expVal);
        vectorCount++;
        assert (int'(dut.cnt_q) === expVal) else begin
            missCount++;
            $error("[TB] FAIL %s: cnt=%0d expected %0d", tag, dut.cnt_q, expVal);
        end
    endtask

    // One start strobe followed by PLEN high cycles and idleAfter low cycles.
    task automatic runPulse(input string tag, input int idleAfter);
        applyStimulus(1'b1, 1'b0);
        checkOutput({tag, "_latency"}, 1'b1);
        for (int i = 2; i <= PLEN; i++) begin
            applyStimulus(1'b0, 1'b0);
            checkOutput({tag, "_high"}, 1'b1);
        end
        for (int i = 0; i < idleAfter; i++) begin
            applyStimulus(1'b0, 1'b0);
            checkOutput({tag, "_low"}, 1'b0);
        end
    endtask

    initial begin
        vectorCount = 0;
        missCount   = 0;
        riseCount   = 0;
        en          = 1'b0;
        rst_n       = 1'b1;

        // Reset held for one cycle with en low.
        @(negedge clk);
        checkOutput("reset_dout", 1'b0);
        checkCount("reset_cnt", 0);

        // Release and stay idle for one cycle.
        applyStimulus(1'b0, 1'b0);
        checkOutput("idle_after_release", 1'b0);

        // Single strobe, then 20 low cycles in total after the start.
        runPulse("single", 20 - (PLEN - 1));
        checkCount("single_cnt_idle", 0);

        // Second strobe after idle gives the identical pulse.
        runPulse("second", 5);

        // Retrigger in cycle 5 and on the terminal edge are both ignored.
        applyStimulus(1'b1, 1'b0);
        checkOutput("retrig_c1", 1'b1);
        checkCount("retrig_cnt1", 1);
        for (int c = 2; c <= PLEN; c++) begin
            applyStimulus((c == 5) || (c == PLEN + 1), 1'b0);
            checkOutput("retrig_high", 1'b1);
        end
        checkCount("retrig_cnt_last", PLEN);
        applyStimulus(1'b1, 1'b0);
        checkOutput("retrig_terminal", 1'b0);
        for (int i = 0; i < 12; i++) begin
            applyStimulus(1'b0, 1'b0);
            checkOutput("retrig_no_second", 1'b0);
        end

        // en held high for 30 edges: 10 high / 1 low, runs start at 1, 12, 23.
        prevDout = 1'b0;
        for (int k = 1; k <= 36; k++) begin
            applyStimulus(k <= 30, 1'b0);
            checkOutput("held", (k <= 33) ? (((k - 1) % 11) < 10) : 1'b0);
            if (dout && !prevDout) riseCount++;
            prevDout = dout;
        end
        vectorCount++;
        assert (riseCount === 3) else begin
            missCount++;
            $error("[TB] FAIL held_rises: rises=%0d expected 3", riseCount);
        end

        // Reset asserted between edges in cycle 4 of a run.
        applyStimulus(1'b1, 1'b0);
        checkOutput("abort_c1", 1'b1);
        for (int c = 2; c <= 4; c++) begin
            applyStimulus(1'b0, 1'b0);
            checkOutput("abort_high", 1'b1);
        end
        #2 rst_n = 1'b1;
        #1;
        checkOutput("abort_async", 1'b0);
        checkCount("abort_cnt", 0);
        @(negedge clk);
        applyStimulus(1'b1, 1'b1);
        checkOutput("abort_en_ignored", 1'b0);
        applyStimulus(1'b0, 1'b0);
        checkOutput("abort_released", 1'b0);
        runPulse("after_abort", 3);

        $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
        $finish;
    end

endmodule : tb_jsq4_1_ctr
